branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a saturating taken/not-taken
// counter per entry. Lookup is combinational; update and flush are applied
// at the next rising edge, with no bypass from a same-cycle update.
// Optional hit/misprediction statistics are enabled with BTB_STATS_EN.
module branch_target_buffer #(
  parameter int unsigned PC_W      = 64,
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned CTR_W     = 2
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [PC_W-1:0] IF_PC,
  output logic [PC_W-1:0] predictedBranchPC,
  output logic            branchTaken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_pred_taken,
  input  logic            flush
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     mispred_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(N_ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = CTR_W'(1) << (CTR_W - 1);

  logic             valid_q  [N_ENTRIES];
  logic [TAG_W-1:0] tag_q    [N_ENTRIES];
  logic [PC_W-1:0]  target_q [N_ENTRIES];
  logic [CTR_W-1:0] ctr_q    [N_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  // Next-state of the single entry addressed by the update port
  logic             entry_we;
  logic             valid_d;
  logic [TAG_W-1:0] tag_d;
  logic [PC_W-1:0]  target_d;
  logic [CTR_W-1:0] ctr_d;

  assign lk_idx = IF_PC[IDX_W+1:2];
  assign lk_tag = IF_PC[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Combinational lookup; target is presented whether or not the tag matches
  always_comb begin
    branchTaken       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) &&
                        ctr_q[lk_idx][CTR_W-1];
    predictedBranchPC = target_q[lk_idx];
  end

  // Compute the updated contents of the indexed entry
  always_comb begin
    entry_we = 1'b0;
    valid_d  = valid_q[up_idx];
    tag_d    = tag_q[up_idx];
    target_d = target_q[up_idx];
    ctr_d    = ctr_q[up_idx];
    if (upd_valid) begin
      if (up_hit) begin
        entry_we = 1'b1;
        if (upd_taken) begin
          target_d = upd_target;
          if (ctr_q[up_idx] != '1) ctr_d = ctr_q[up_idx] + CTR_W'(1);
        end else begin
          if (ctr_q[up_idx] != '0) ctr_d = ctr_q[up_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        entry_we = 1'b1;
        valid_d  = 1'b1;
        tag_d    = up_tag;
        target_d = upd_target;
        ctr_d    = CTR_WEAK_TAKEN;
      end
    end
  end

  // Entry storage: reset clears everything, flush clears only valid bits
  // and drops any concurrent update
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (entry_we) begin
      valid_q[up_idx]  <= valid_d;
      tag_q[up_idx]    <= tag_d;
      target_q[up_idx] <= target_d;
      ctr_q[up_idx]    <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Saturating statistics; flush does not touch them
  always_comb begin
    hit_cnt_d     = hit_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid && up_hit && (hit_cnt_q != '1))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (upd_valid && (upd_taken != upd_pred_taken) && (mispred_cnt_q != '1))
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hit_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      hit_cnt_q     <= hit_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign hit_cnt     = hit_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  logic lint_unused;
  assign lint_unused = ^{IF_PC, upd_pc};
`else
  logic lint_unused;
  assign lint_unused = ^{IF_PC, upd_pc, upd_pred_taken};
`endif

endmodule
